// File: rtl/wb_bus_arbiter.sv
// Round-robin arbiter sharing one 16-bit Wishbone slave among NUM_MASTERS
// masters, aborting any access that sees no ack within TIMEOUT cycles.
module wb_bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int TIMEOUT     = 1000,
    parameter int TO_WIDTH    = 10
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic [NUM_MASTERS-1:0]    wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]    wbm_stb_i,
    input  logic [NUM_MASTERS-1:0]    wbm_we_i,
    input  logic [16*NUM_MASTERS-1:0] wbm_adr_i,
    input  logic [16*NUM_MASTERS-1:0] wbm_dat_i,
    output logic [15:0]               wbm_dat_o,
    output logic [NUM_MASTERS-1:0]    wbm_ack_o,
    output logic [NUM_MASTERS-1:0]    wbm_err_o,
    output logic                      wbs_cyc_o,
    output logic                      wbs_stb_o,
    output logic                      wbs_we_o,
    output logic [15:0]               wbs_adr_o,
    output logic [15:0]               wbs_dat_o,
    input  logic [15:0]               wbs_dat_i,
    input  logic                      wbs_ack_i,
    output logic                      timeout_o,
    output logic [2:0]                timeout_master_o
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_ABORT,
        S_RELEASE
    } state_t;

    state_t              r_state;
    logic [IW-1:0]       r_grant;
    logic [IW-1:0]       r_last;
    logic [TO_WIDTH-1:0] r_cnt;
    logic [2:0]          r_to_master;

    logic [IW-1:0]       w_win;
    logic [IW-1:0]       w_idx;
    logic                w_found;
    logic                w_cyc;
    logic                w_stb;
    logic                w_wait;
    logic                w_to;

    assign w_cyc  = wbm_cyc_i[r_grant];
    assign w_stb  = wbm_stb_i[r_grant];
    assign w_wait = (r_state == S_GRANT) && w_stb && !wbs_ack_i;
    // Raw stb is used so an abort still fires if cyc drops on the final cycle
    assign w_to   = w_wait && (r_cnt == TO_WIDTH'(TIMEOUT - 1));

    always_comb begin
        w_found = 1'b0;
        w_win   = r_last;
        w_idx   = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            w_idx = IW'((int'(r_last) + k) % NUM_MASTERS);
            if (!w_found && wbm_cyc_i[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        wbs_cyc_o = (r_state == S_GRANT) && w_cyc;
        wbs_stb_o = wbs_cyc_o && w_stb;
        wbs_we_o  = wbs_cyc_o && wbm_we_i[r_grant];
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        if (wbs_cyc_o) begin
            wbs_adr_o = wbm_adr_i[int'(r_grant)*16 +: 16];
            wbs_dat_o = wbm_dat_i[int'(r_grant)*16 +: 16];
        end
        wbm_ack_o = '0;
        wbm_err_o = '0;
        if (r_state == S_GRANT) begin
            wbm_ack_o[r_grant] = wbs_ack_i;
        end
        if (r_state == S_ABORT) begin
            wbm_err_o[r_grant] = 1'b1;
        end
        wbm_dat_o        = wbs_dat_i;
        timeout_o        = (r_state == S_ABORT);
        timeout_master_o = r_to_master;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_last      <= IW'(NUM_MASTERS - 1);
            r_cnt       <= '0;
            r_to_master <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_found) begin
                        r_grant <= w_win;
                        r_last  <= w_win;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (w_to) begin
                        r_state     <= S_ABORT;
                        r_to_master <= 3'(r_grant);
                        r_cnt       <= '0;
                    end else if (!w_cyc) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (w_wait) begin
                        r_cnt <= r_cnt + TO_WIDTH'(1);
                    end else begin
                        r_cnt <= '0;
                    end
                end
                S_ABORT: begin
                    r_state <= S_RELEASE;
                end
                S_RELEASE: begin
                    if (!w_cyc) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
